wb_master_bridge: RTL and testbench
===================================

Name: wb_master_bridge

Overview:
- Converts the core's valid/ready memory request interface into single Wishbone classic transfers.
- Drives the master side of the combinational 1:N bus interconnect and returns one response per request to the core.
- Owns the bus-cycle state machine and a no-response timeout, so a stalled or missing slave can never hang the core.

Parameters:
- TimeoutCycles, 255: bus cycles allowed without ack/err before the transfer is aborted with an error. 0 disables the timeout.
- CounterWidth, 8: width of the timeout counter. Must satisfy 2^CounterWidth > TimeoutCycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  bridge can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  response carries an error (slave err, interconnect decode err, or timeout).
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write enable.
- wb_sel  out  4  Wishbone byte select.
- wb_addr  out  32  Wishbone address.
- wb_wdata  out  32  Wishbone write data.
- wb_ack  in  1  slave acknowledge, via the interconnect.
- wb_err  in  1  bus error, via the interconnect.
- wb_rdata  in  32  read data, via the interconnect.

Behaviour:
- Reset: all outputs 0 except req_ready = 1. State is IDLE and the counter is 0. The asynchronous assertion drops wb_cyc/wb_stb immediately, including mid-transfer. The in-flight request is discarded and no response is issued.
- States: IDLE and BUS. All Wishbone and response outputs are registered.
- req_ready = (state == IDLE).
- IDLE, on req_valid: latch we/addr/wdata/be into the wb_* registers, set wb_cyc = wb_stb = 1, clear the counter, go to BUS. The first bus cycle is the edge after the handshake.
- BUS, wb_err = 1: drop cyc/stb. Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0. Go to IDLE. err wins over a simultaneous ack.
- BUS, wb_ack = 1 and wb_err = 0: drop cyc/stb. Next cycle: resp_valid = 1, resp_err = 0. resp_rdata = wb_rdata for a read, 0 for a write. Go to IDLE.
- BUS, neither ack nor err: increment the counter.
  - If TimeoutCycles != 0 and the counter == TimeoutCycles-1 on this edge, abort: drop cyc/stb and respond as for err.
  - Total bus occupancy on a timeout is exactly TimeoutCycles cycles.
- Termination is sampled only while wb_cyc & wb_stb are high. ack/err seen in IDLE are ignored.
- Response cycle overlaps IDLE: req_ready = 1 while resp_valid = 1. A new request can be accepted then, giving a new wb_cyc on the following edge. This is back-to-back throughput of one transfer per 2 cycles with a zero-wait slave.
- resp_valid is a single pulse with no backpressure; the core must consume it.
- wb_we/wb_sel/wb_addr/wb_wdata:
  - hold stable for the whole BUS state;
  - return to 0 when cyc drops, so no stale address is seen by the interconnect decoders.
- Read latency, request handshake to resp_valid, is 2 + W cycles, where W is the number of slave wait states.
- Address alignment is not checked; wb_addr passes req_addr unchanged.

Decomposition:
- A shared package wb_pkg holds:
  - the state enum (BUS_IDLE, BUS_ACTIVE);
  - the constant WB_DATA_W = 32;
  - the constant WB_SEL_W = 4;
  - a wb_req_t struct (we, sel, addr, wdata) used for the latched request register.
- The timeout counter is a natural sub-module, wb_timeout_counter, with inputs clear/enable/limit and output expired. It is reusable by other bus masters.

Test Plan:
- Zero-wait read: req addr 0x1000_0004, slave acks in the first BUS cycle with rdata 0xDEAD_BEEF -> wb_cyc high for 1 cycle; resp_valid at handshake+2; resp_rdata 0xDEAD_BEEF; resp_err 0.
- Write with 3 wait states: we = 1, wdata 0x1234_5678, be 0x3 -> wb_sel 0x3 and wb_wdata stable for 4 cycles; resp_valid at handshake+5; resp_rdata 0; resp_err 0.
- Decode error: addr 0xFFFF_0000 with the interconnect asserting err in the first cycle -> resp_err 1, resp_rdata 0. Simultaneous ack + err -> resp_err 1.
- Timeout: TimeoutCycles = 4, slave never responds -> wb_cyc high exactly 4 cycles, then resp_valid with resp_err 1. Disable case: TimeoutCycles = 0, no ack for 1000 cycles -> wb_cyc remains high and no response.
- Back-to-back: req_valid held high for two requests, zero-wait slave -> second wb_cyc rises the cycle after the first resp_valid, with no gap beyond 1 idle bus cycle.
- Reset mid-transfer: reset_n low during BUS wait -> wb_cyc/wb_stb go 0 asynchronously, no resp_valid, and req_ready = 1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone master bridge and related bus masters.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [0:0] {
    BUS_IDLE   = 1'b0,
    BUS_ACTIVE = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [31:0]          addr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter for bus no-response timeouts; expired flags the last allowed cycle.
module wb_timeout_counter #(
  parameter int CounterWidth = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [CounterWidth-1:0] limit,
  output logic                    expired
);

  logic [CounterWidth-1:0] cnt_q;
  logic [CounterWidth-1:0] cnt_d;

  // A zero limit never expires, so the counter simply wraps.
  assign expired = (limit != '0) && (cnt_q == (limit - CounterWidth'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CounterWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_bridge.sv
// Turns valid/ready core requests into single Wishbone classic transfers with a
// one-cycle response pulse, an error path and a no-response timeout.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int TimeoutCycles = 255,
  parameter int CounterWidth  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [WB_DATA_W-1:0] req_wdata,
  input  logic [WB_SEL_W-1:0]  req_be,
  output logic                 resp_valid,
  output logic [WB_DATA_W-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [WB_SEL_W-1:0]  wb_sel,
  output logic [31:0]          wb_addr,
  output logic [WB_DATA_W-1:0] wb_wdata,
  input  logic                 wb_ack,
  input  logic                 wb_err,
  input  logic [WB_DATA_W-1:0] wb_rdata
);

  localparam logic [CounterWidth-1:0] Limit = CounterWidth'(TimeoutCycles);

  wb_state_e            state_q, state_d;
  wb_req_t              req_q, req_d;
  logic                 cyc_q, cyc_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [WB_DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic accept;
  logic active;
  logic term_err;
  logic term_ack;
  logic expired;
  logic timeout;

  assign req_ready = (state_q == BUS_IDLE);
  assign accept    = req_valid && req_ready;

  // Termination is only meaningful while a cycle is actually on the bus.
  assign active   = (state_q == BUS_ACTIVE) && cyc_q;
  assign term_err = active && wb_err;
  assign term_ack = active && wb_ack && !wb_err;
  assign timeout  = active && !wb_ack && !wb_err && expired;

  wb_timeout_counter #(
    .CounterWidth(CounterWidth)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (active && !wb_ack && !wb_err),
    .limit   (Limit),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    cyc_d        = cyc_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      BUS_IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.sel   = req_be;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          cyc_d       = 1'b1;
          state_d     = BUS_ACTIVE;
        end
      end
      BUS_ACTIVE: begin
        if (term_err || term_ack || timeout) begin
          // Clearing the request keeps stale addresses off the decoders.
          req_d        = '0;
          cyc_d        = 1'b0;
          state_d      = BUS_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = term_err || timeout;
          resp_rdata_d = (term_ack && !req_q.we) ? wb_rdata : '0;
        end
      end
      default: begin
        state_d = BUS_IDLE;
        cyc_d   = 1'b0;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BUS_IDLE;
      req_q        <= '0;
      cyc_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cyc_q        <= cyc_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = req_q.we;
  assign wb_sel     = req_q.sel;
  assign wb_addr    = req_q.addr;
  assign wb_wdata   = req_q.wdata;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench: one bridge with a 4-cycle timeout, one with the timeout disabled.
module tb_wb_master_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_rdata;

  logic        r4_req_ready, r4_resp_valid, r4_resp_err, r4_cyc, r4_stb, r4_we;
  logic [31:0] r4_resp_rdata, r4_addr, r4_wdata;
  logic [3:0]  r4_sel;
  logic        r0_req_ready, r0_resp_valid, r0_resp_err, r0_cyc, r0_stb, r0_we;
  logic [31:0] r0_resp_rdata, r0_addr, r0_wdata;
  logic [3:0]  r0_sel;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_master_bridge #(.TimeoutCycles(4), .CounterWidth(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(r4_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r4_resp_valid), .resp_rdata(r4_resp_rdata), .resp_err(r4_resp_err),
    .wb_cyc(r4_cyc), .wb_stb(r4_stb), .wb_we(r4_we), .wb_sel(r4_sel),
    .wb_addr(r4_addr), .wb_wdata(r4_wdata),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rdata(wb_rdata)
  );

  wb_master_bridge #(.TimeoutCycles(0), .CounterWidth(8)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(r0_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(r0_resp_valid), .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err),
    .wb_cyc(r0_cyc), .wb_stb(r0_stb), .wb_we(r0_we), .wb_sel(r0_sel),
    .wb_addr(r0_addr), .wb_wdata(r0_wdata),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_rdata(wb_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic handshake(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_be = '0; wb_ack = 0; wb_err = 0; wb_rdata = '0;
    #3;
    checks++;
    if ({r4_req_ready, r4_resp_valid, r4_resp_err, r4_cyc, r4_stb, r4_we} !== 6'b100000)
      $display("FAIL reset_ctrl: got %b expected 100000",
               {r4_req_ready, r4_resp_valid, r4_resp_err, r4_cyc, r4_stb, r4_we});
    else passed++;
    checks++;
    if ({r4_addr, r4_wdata, r4_sel, r4_resp_rdata} !== '0)
      $display("FAIL reset_data: got addr %h wdata %h sel %h rdata %h expected all 0",
               r4_addr, r4_wdata, r4_sel, r4_resp_rdata);
    else passed++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_wait_read;
    handshake(1'b0, 32'h1000_0004, 32'h0, 4'hF);
    checks++;
    if ({r4_cyc, r4_stb, r4_we, r4_addr, r4_req_ready} !== {3'b110, 32'h1000_0004, 1'b0})
      $display("FAIL read_bus: got cyc %b stb %b we %b addr %h rdy %b expected 1 1 0 10000004 0",
               r4_cyc, r4_stb, r4_we, r4_addr, r4_req_ready);
    else passed++;
    wb_ack = 1'b1; wb_rdata = 32'hDEAD_BEEF;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    checks++;
    if ({r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata, r4_addr} !==
        {3'b010, 32'hDEAD_BEEF, 32'h0})
      $display("FAIL read_resp: got cyc %b vld %b err %b rdata %h addr %h expected 0 1 0 deadbeef 0",
               r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata, r4_addr);
    else passed++;
    tick();
    checks++;
    if (r4_resp_valid !== 1'b0)
      $display("FAIL read_pulse: got resp_valid %b expected 0", r4_resp_valid);
    else passed++;
  endtask

  task automatic test_write_wait;
    bit stable = 1'b1;
    handshake(1'b1, 32'h2000_0010, 32'h1234_5678, 4'h3);
    wb_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 4; i++) begin
      if ({r4_cyc, r4_we, r4_sel, r4_wdata, r4_addr, r4_resp_valid} !==
          {2'b11, 4'h3, 32'h1234_5678, 32'h2000_0010, 1'b0})
        stable = 1'b0;
      if (i == 3) wb_ack = 1'b1;
      tick();
    end
    wb_ack = 1'b0; wb_rdata = '0;
    checks++;
    if (stable !== 1'b1)
      $display("FAIL write_stable: got stable %b expected 1", stable);
    else passed++;
    checks++;
    if ({r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata, r4_sel, r4_wdata} !==
        {3'b010, 32'h0, 4'h0, 32'h0})
      $display("FAIL write_resp: got cyc %b vld %b err %b rdata %h sel %h wdata %h expected 0 1 0 0 0 0",
               r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata, r4_sel, r4_wdata);
    else passed++;
    tick();
  endtask

  task automatic test_errors;
    handshake(1'b0, 32'hFFFF_0000, 32'h0, 4'hF);
    wb_err = 1'b1; wb_rdata = 32'h5A5A_5A5A;
    tick();
    wb_err = 1'b0;
    checks++;
    if ({r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata} !== {3'b011, 32'h0})
      $display("FAIL decode_err: got cyc %b vld %b err %b rdata %h expected 0 1 1 0",
               r4_cyc, r4_resp_valid, r4_resp_err, r4_resp_rdata);
    else passed++;
    tick();
    handshake(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    wb_err = 1'b1; wb_ack = 1'b1;
    tick();
    wb_err = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    checks++;
    if ({r4_resp_valid, r4_resp_err, r4_resp_rdata} !== {2'b11, 32'h0})
      $display("FAIL ack_err_both: got vld %b err %b rdata %h expected 1 1 0",
               r4_resp_valid, r4_resp_err, r4_resp_rdata);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100; req_be = 4'hF;
    tick();
    req_addr = 32'h0000_0200;
    wb_ack = 1'b1; wb_rdata = 32'h1111_1111;
    tick();
    checks++;
    if ({r4_cyc, r4_resp_valid, r4_req_ready, r4_resp_rdata} !== {3'b011, 32'h1111_1111})
      $display("FAIL b2b_first: got cyc %b vld %b rdy %b rdata %h expected 0 1 1 11111111",
               r4_cyc, r4_resp_valid, r4_req_ready, r4_resp_rdata);
    else passed++;
    wb_rdata = 32'h2222_2222;
    tick();
    req_valid = 1'b0; req_addr = '0;
    checks++;
    if ({r4_cyc, r4_addr, r4_resp_valid} !== {1'b1, 32'h0000_0200, 1'b0})
      $display("FAIL b2b_second_cyc: got cyc %b addr %h vld %b expected 1 00000200 0",
               r4_cyc, r4_addr, r4_resp_valid);
    else passed++;
    tick();
    wb_ack = 1'b0; wb_rdata = '0;
    checks++;
    if ({r4_cyc, r4_resp_valid, r4_resp_rdata} !== {2'b01, 32'h2222_2222})
      $display("FAIL b2b_second_resp: got cyc %b vld %b rdata %h expected 0 1 22222222",
               r4_cyc, r4_resp_valid, r4_resp_rdata);
    else passed++;
    tick();
  endtask

  task automatic test_timeout;
    int high = 0;
    int resp_at = -1;
    handshake(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (r4_cyc) high++;
      if (r4_resp_valid && resp_at < 0) resp_at = i;
      if (resp_at >= 0) break;
      tick();
    end
    checks++;
    if (high !== 4)
      $display("FAIL timeout_len: got %0d cycles expected 4", high);
    else passed++;
    checks++;
    if (resp_at !== 4 || r4_resp_err !== 1'b1 || r4_resp_rdata !== 32'h0)
      $display("FAIL timeout_resp: got at %0d err %b rdata %h expected at 4 err 1 rdata 0",
               resp_at, r4_resp_err, r4_resp_rdata);
    else passed++;
  endtask

  // Continues from the timeout handshake: the disabled bridge must still be waiting.
  task automatic test_timeout_disabled;
    bit stuck = 1'b1;
    bit silent = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!r0_cyc || !r0_stb) stuck = 1'b0;
      if (r0_resp_valid) silent = 1'b0;
      tick();
    end
    checks++;
    if (stuck !== 1'b1)
      $display("FAIL notimeout_cyc: got held %b expected 1", stuck);
    else passed++;
    checks++;
    if (silent !== 1'b1)
      $display("FAIL notimeout_resp: got silent %b expected 1", silent);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit silent = 1'b1;
    handshake(1'b1, 32'h5000_0000, 32'hCAFE_F00D, 4'hF);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({r4_cyc, r4_stb, r0_cyc, r0_stb, r4_addr} !== {4'b0000, 32'h0})
      $display("FAIL reset_async: got cyc4 %b stb4 %b cyc0 %b stb0 %b addr %h expected 0 0 0 0 0",
               r4_cyc, r4_stb, r0_cyc, r0_stb, r4_addr);
    else passed++;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (r4_resp_valid || r0_resp_valid) silent = 1'b0;
      tick();
    end
    checks++;
    if ({silent, r4_req_ready, r0_req_ready} !== 3'b111)
      $display("FAIL reset_after: got silent %b rdy4 %b rdy0 %b expected 1 1 1",
               silent, r4_req_ready, r0_req_ready);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_timeout_disabled();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
